// File: rtl/can_rx_destuff.sv
// CAN receive front end: synchronises the RX pin, raises the hard-sync
// pulse for the bit timing logic, samples the bus on each sample point,
// detects SOF, removes stuff bits, flags stuff errors and integrates
// bus-idle. Delivers one destuffed bit per bit time to the frame decoder.
module can_rx_destuff #(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_BITS   = 11,
  parameter int STUFF_LEN   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic can_rx,
  input  logic sample_point,
  input  logic destuff_en,
  output logic rx_sync_edge,
  output logic bus_idle,
  output logic bit_valid,
  output logic bit_data,
  output logic sof,
  output logic stuff_err
);

  localparam int REC_W = $clog2(IDLE_BITS + 1);
  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam logic [REC_W-1:0] REC_MAX = REC_W'(IDLE_BITS);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  typedef enum logic [1:0] {
    ST_INTEGRATE,
    ST_IDLE,
    ST_RECEIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_d;
  state_t                 state;
  logic [REC_W-1:0]       rec_cnt;
  logic [RUN_W-1:0]       run_cnt;
  logic                   last_bit;
  logic [REC_W-1:0]       rec_nx;

  // Recessive-run count after one more sample; saturates at IDLE_BITS.
  function automatic logic [REC_W-1:0] rec_next(input logic [REC_W-1:0] cnt,
                                                input logic             smp);
    if (!smp)
      return '0;
    if (cnt == REC_MAX)
      return cnt;
    return cnt + 1'b1;
  endfunction

  // Identical-bit run length after one more emitted bit. A zero count means
  // counting was suspended (unstuffed region), so the bit starts a new run.
  function automatic logic [RUN_W-1:0] run_next(input logic [RUN_W-1:0] cnt,
                                                input logic             smp,
                                                input logic             last);
    if ((cnt == '0) || (smp != last))
      return RUN_ONE;
    if (cnt == RUN_MAX)
      return cnt;
    return cnt + 1'b1;
  endfunction

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign rec_nx = rec_next(rec_cnt, rx_s);

  // Metastability synchroniser for the raw pin plus a one-clk delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], can_rx};
      rx_d   <= rx_s;
    end
  end

  // Hard-sync pulse on a recessive-to-dominant edge while the bus is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rx_sync_edge <= 1'b0;
    else
      rx_sync_edge <= (state == ST_IDLE) && rx_d && !rx_s;
  end

  // Bit-level state machine; advances only on sample_point, outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INTEGRATE;
      rec_cnt   <= '0;
      run_cnt   <= '0;
      last_bit  <= 1'b1;
      bus_idle  <= 1'b0;
      bit_valid <= 1'b0;
      bit_data  <= 1'b1;
      sof       <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      sof       <= 1'b0;
      stuff_err <= 1'b0;
      if (sample_point) begin
        case (state)
          ST_INTEGRATE: begin
            rec_cnt <= rec_nx;
            run_cnt <= '0;
            if (rec_nx == REC_MAX) begin
              state    <= ST_IDLE;
              bus_idle <= 1'b1;
            end
          end

          ST_IDLE: begin
            // A recessive sample here is a glitch-triggered sync; ignore it.
            if (!rx_s) begin
              bit_valid <= 1'b1;
              bit_data  <= 1'b0;
              sof       <= 1'b1;
              last_bit  <= 1'b0;
              run_cnt   <= RUN_ONE;
              rec_cnt   <= '0;
              bus_idle  <= 1'b0;
              state     <= ST_RECEIVE;
            end
          end

          ST_RECEIVE: begin
            if (destuff_en) begin
              rec_cnt <= rec_nx;
              if (run_cnt == RUN_MAX) begin
                // This sample is the stuff bit: it must invert the run.
                if (rx_s != last_bit) begin
                  run_cnt  <= RUN_ONE;
                  last_bit <= rx_s;
                end else begin
                  stuff_err <= 1'b1;
                  run_cnt   <= '0;
                  rec_cnt   <= '0;
                  state     <= ST_INTEGRATE;
                end
              end else begin
                bit_valid <= 1'b1;
                bit_data  <= rx_s;
                run_cnt   <= run_next(run_cnt, rx_s, last_bit);
                last_bit  <= rx_s;
              end
            end else begin
              // Unstuffed tail: pass every bit, watch for end-of-frame idle.
              bit_valid <= 1'b1;
              bit_data  <= rx_s;
              run_cnt   <= '0;
              last_bit  <= rx_s;
              rec_cnt   <= rec_nx;
              if (rec_nx == REC_MAX) begin
                state    <= ST_IDLE;
                bus_idle <= 1'b1;
              end
            end
          end

          default: begin
            state   <= ST_INTEGRATE;
            rec_cnt <= '0;
            run_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_rx_destuff.sv
// Randomised self-checking bench for can_rx_destuff with a bit-level
// reference model of SOF detection, destuffing and idle integration.
module tb_can_rx_destuff;

  localparam int SYNC_STAGES = 2;
  localparam int IDLE_BITS   = 11;
  localparam int STUFF_LEN   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic can_rx = 1'b1;
  logic sample_point = 1'b0;
  logic destuff_en = 1'b0;
  logic rx_sync_edge, bus_idle, bit_valid, bit_data, sof, stuff_err;

  int checks = 0;
  int failures = 0;
  int sync_pulses = 0;

  // Reference model state (bus view in terms of the protocol rules)
  bit m_idle, m_frame, m_last;
  int m_streak, m_run;
  bit e_bv, e_bd, e_sof, e_err, e_idle;

  can_rx_destuff #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE_BITS  (IDLE_BITS),
    .STUFF_LEN  (STUFF_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .can_rx      (can_rx),
    .sample_point(sample_point),
    .destuff_en  (destuff_en),
    .rx_sync_edge(rx_sync_edge),
    .bus_idle    (bus_idle),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .sof         (sof),
    .stuff_err   (stuff_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && rx_sync_edge) sync_pulses++;

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 0; m_frame = 0; m_last = 1; m_streak = 0; m_run = 0;
    e_bv = 0; e_bd = 1; e_sof = 0; e_err = 0; e_idle = 0;
  endtask

  // Expected response to one sampled bus bit
  task automatic model_sample(input bit s, input bit de);
    e_bv = 0; e_sof = 0; e_err = 0;
    if (m_idle) begin
      if (!s) begin
        e_bv = 1; e_bd = 0; e_sof = 1;
        m_idle = 0; m_frame = 1; m_run = 1; m_last = 0; m_streak = 0;
      end
    end else if (!m_frame) begin
      m_streak = s ? m_streak + 1 : 0;
      if (m_streak >= IDLE_BITS) m_idle = 1;
    end else begin
      m_streak = s ? m_streak + 1 : 0;
      if (de) begin
        if (m_run == STUFF_LEN) begin
          if (s != m_last) begin
            m_run = 1; m_last = s;
          end else begin
            e_err = 1; m_frame = 0; m_streak = 0; m_run = 0;
          end
        end else begin
          e_bv = 1; e_bd = s;
          m_run = (m_run > 0 && s == m_last) ? m_run + 1 : 1;
          m_last = s;
        end
      end else begin
        e_bv = 1; e_bd = s; m_run = 0; m_last = s;
        if (m_streak >= IDLE_BITS) begin
          m_frame = 0; m_idle = 1;
        end
      end
    end
    e_idle = m_idle;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_bit_valid"}, bit_valid, e_bv);
    chk({tag, "_bit_data"},  bit_data,  e_bd);
    chk({tag, "_sof"},       sof,       e_sof);
    chk({tag, "_stuff_err"}, stuff_err, e_err);
    chk({tag, "_bus_idle"},  bus_idle,  e_idle);
  endtask

  // Present one bit, let it settle through the synchroniser, strobe sample_point.
  // Entered and left at #1 after a rising edge.
  task automatic send_bit(input bit s, input bit de, input string tag);
    can_rx = s;
    destuff_en = de;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1 sample_point = 1'b1;
    @(posedge clk);
    #1 sample_point = 1'b0;
    model_sample(s, de);
    check_outputs(tag);
    @(posedge clk);
    #1;
    chk({tag, "_gap_bit_valid"}, bit_valid, 1'b0);
    chk({tag, "_gap_stuff_err"}, stuff_err, 1'b0);
  endtask

  initial begin
    bit v;
    int nb, len, sent;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset_sync_edge", rx_sync_edge, 1'b0);
    rst = 1'b0;

    // Integration to idle with no hard-sync activity
    for (int i = 0; i < IDLE_BITS; i++) send_bit(1'b1, 1'b0, "integ");
    chk("integ_idle", bus_idle, 1'b1);
    chk("integ_no_sync", sync_pulses, 0);

    // Hard sync: single pulse SYNC_STAGES+1 clocks after the falling edge
    can_rx = 1'b0;
    for (int i = 1; i <= SYNC_STAGES + 3; i++) begin
      @(posedge clk);
      #1 chk("hsync_cycle", rx_sync_edge, (i == SYNC_STAGES + 1) ? 1'b1 : 1'b0);
    end
    chk("hsync_count", sync_pulses, 1);
    send_bit(1'b0, 1'b1, "sof");

    // SOF + 0000 + stuff 1 + 1
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, "run0");
    send_bit(1'b1, 1'b1, "stuff1");
    send_bit(1'b1, 1'b1, "after_stuff");

    // Unstuffed tail of 11 recessive bits returns to idle
    for (int i = 0; i < IDLE_BITS; i++) send_bit(1'b1, 1'b0, "tail");
    chk("tail_idle", bus_idle, 1'b1);

    // SOF + 00000: stuff error on the sixth dominant sample
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1, "err6");
    for (int i = 0; i < IDLE_BITS; i++) send_bit(1'b1, 1'b0, "reinteg");
    chk("reinteg_idle", bus_idle, 1'b1);

    // Asynchronous reset while a dominant bit is on the outputs
    send_bit(1'b0, 1'b1, "pre_rst_sof");
    send_bit(1'b1, 1'b1, "pre_rst_b1");
    can_rx = 1'b0;
    destuff_en = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1 sample_point = 1'b1;
    @(posedge clk);
    #1 sample_point = 1'b0;
    model_sample(1'b0, 1'b1);
    check_outputs("pre_rst_b2");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst_sync_edge", rx_sync_edge, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_bit(1'b0, 1'b1, "post_rst_d");
    for (int i = 0; i < IDLE_BITS; i++) send_bit(1'b1, 1'b1, "post_rst_r");
    chk("post_rst_idle", bus_idle, 1'b1);

    // Randomised frames
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < IDLE_BITS; i++) send_bit(1'b1, 1'b0, "rnd_idle");
      chk("rnd_bus_idle", bus_idle, 1'b1);
      if ($urandom_range(0, 3) == 0) send_bit(1'b1, 1'b1, "rnd_glitch");
      send_bit(1'b0, 1'b1, "rnd_sof");
      nb = $urandom_range(10, 30);
      sent = 0;
      v = 1'($urandom);
      while (sent < nb) begin
        len = ($urandom_range(0, 9) == 0) ? STUFF_LEN + 1 : $urandom_range(1, STUFF_LEN);
        for (int k = 0; k < len; k++) send_bit(v, 1'b1, "rnd_stuffed");
        sent += len;
        v = ~v;
      end
      nb = $urandom_range(0, 8);
      for (int i = 0; i < nb; i++) send_bit(1'($urandom), 1'b0, "rnd_plain");
      nb = $urandom_range(0, 6);
      for (int i = 0; i < nb; i++) send_bit(1'($urandom), 1'b1, "rnd_restuff");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_rx_destuff.md
Name: can_rx_destuff

Overview:
Receive-side bit-stream front end for the CAN controller, sitting directly downstream of the bit timing logic. It does three things:
- Synchronises the raw CAN RX pin and generates the hard-sync pulse that feeds the bit timing logic's `rx_sync_edge`.
- Samples the bus on each `sample_point` from the bit timing logic.
- Detects SOF, removes stuff bits, flags stuff errors and tracks bus-idle integration.

It delivers destuffed bits, one per bit time, to the frame decoder. The frame decoder tells it, through `destuff_en`, when stuffing applies.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `can_rx` synchroniser (minimum 2).
- IDLE_BITS, 11, consecutive recessive samples required to declare the bus idle.
- STUFF_LEN, 5, run length of identical bits after which a stuff bit is expected.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- can_rx  in  1  raw CAN RX pin, asynchronous to clk; 1 = recessive.
- sample_point  in  1  one-clk pulse from the bit timing logic marking the bit sample instant.
- destuff_en  in  1  from the frame decoder; 1 = stuffed region (SOF through CRC sequence).
- rx_sync_edge  out  1  one-clk hard-sync pulse to the bit timing logic.
- bus_idle  out  1  1 while in IDLE.
- bit_valid  out  1  one-clk pulse: `bit_data` holds a new destuffed bit.
- bit_data  out  1  destuffed bit value.
- sof  out  1  asserted together with `bit_valid` for the SOF bit only.
- stuff_err  out  1  one-clk pulse on a stuff violation.

Behaviour:

Reset and synchroniser
- Reset (asynchronous) forces all synchroniser flops to 1, state = INTEGRATE, and all counters to 0.
- Output reset values: `rx_sync_edge`=0, `bus_idle`=0, `bit_valid`=0, `bit_data`=1, `sof`=0, `stuff_err`=0.
- Reset mid-frame abandons the frame; no `bit_valid` or `stuff_err` is produced until integration completes again.
- `rx_s` is the last synchroniser stage. `rx_d` is `rx_s` delayed by one clk.

Hard sync
- `rx_sync_edge` is registered: it is 1 in the cycle after `rx_d`=1 and `rx_s`=0 while state = IDLE, and 0 at all other times.

Outputs from sampling
- Every output produced by a sample is registered: it appears exactly 1 clk after the `sample_point` cycle and lasts 1 clk.
- The sampled value is `rx_s` in the `sample_point` cycle.

State machine (states: INTEGRATE, IDLE, RECEIVE)

INTEGRATE
- `rec_cnt` counts consecutive recessive samples; a dominant sample clears it to 0.
- When `rec_cnt` reaches IDLE_BITS, go to IDLE. `rec_cnt` saturates and never wraps.

IDLE
- `bus_idle`=1.
- A dominant sample is treated as SOF: pulse `bit_valid`=1, `bit_data`=0, `sof`=1. Load `last_bit`=0 and `run_cnt`=1, then go to RECEIVE.
- A recessive sample (e.g. a glitch-triggered hard sync) is ignored and the state stays IDLE.

RECEIVE, with `destuff_en`=1
- If `run_cnt` = STUFF_LEN, the current sample is the stuff bit:
  - If it differs from `last_bit`, drop it (no `bit_valid`) and set `run_cnt`=1, `last_bit`=sample.
  - If it equals `last_bit`, pulse `stuff_err`, emit no `bit_valid`, clear counters and go to INTEGRATE.
- Otherwise, pulse `bit_valid` with `bit_data`=sample:
  - If sample = `last_bit`, increment `run_cnt`; otherwise set `run_cnt`=1.
  - Then set `last_bit`=sample.

RECEIVE, with `destuff_en`=0
- Every sample is emitted as `bit_valid`; no stuff checking is done.
- `run_cnt` is held at 0. If `destuff_en` rises again, run counting restarts with the next bit, counting it as `run_cnt`=1.
- `rec_cnt` tracks consecutive recessive samples. When it reaches IDLE_BITS, emit the bit and then go to IDLE.

Counter widths and timing
- `run_cnt` and `rec_cnt` are wide enough to hold STUFF_LEN and IDLE_BITS respectively; neither wraps.
- `destuff_en` is sampled in the same cycle as `sample_point`.
- Without a `sample_point` pulse, the state and counters never change.

Test Plan:
- Reset, hold `can_rx`=1, issue 11 `sample_point` pulses → `bus_idle` rises 1 clk after the 11th; `rx_sync_edge` stays 0 throughout.
- From IDLE, drive `can_rx` 1→0 → `rx_sync_edge` is a single 1-clk pulse SYNC_STAGES+1 clks after the edge. Next `sample_point` → `bit_valid`=1, `sof`=1, `bit_data`=0, `bus_idle`=0.
- `destuff_en`=1, send SOF + 0000 + stuff 1 + 1 → output bits 0,0,0,0,0,1; the stuff bit produces no `bit_valid`; `stuff_err` stays 0.
- `destuff_en`=1, send SOF + 00000 (six dominant in total) → 5 `bit_valid` pulses, then a `stuff_err` pulse on the 6th sample with no `bit_valid`; state = INTEGRATE and `bus_idle` stays 0 until 11 recessive samples.
- `destuff_en`=0 in RECEIVE, send 11 recessive bits → all 11 emitted with no `stuff_err`; `bus_idle` rises 1 clk after the 11th.
- Assert `rst` mid-frame between two `sample_point` pulses → all outputs at reset values immediately (asynchronous); no further `bit_valid` until 11 recessive samples have been integrated.
